// File: rtl/bus_pkg.sv
// Shared JB-8 bus definitions: FSM states, decoder regions and the address map.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package bus_pkg;

    localparam int CNT_W_DEFAULT = 4;

    // JB-8 address map as seen by the region decoder.
    localparam logic [15:0] RAM_HI       = 16'hDFFF;
    localparam logic [15:0] IO_BASE      = 16'hE000;
    localparam logic [15:0] IO_SLOT_SIZE = 16'h0010;
    localparam logic [15:0] RSVD_LO      = 16'hE040;
    localparam logic [15:0] RSVD_HI      = 16'hE0FF;
    localparam logic [15:0] ROM_LO       = 16'hE100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXT  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        REG_NONE = 3'd0,
        REG_RAM  = 3'd1,
        REG_ROM  = 3'd2,
        REG_IO0  = 3'd3,
        REG_IO1  = 3'd4,
        REG_IO2  = 3'd5,
        REG_IO3  = 3'd6
    } region_e;

    // Reference decode of a CPU address into a region; mirrors the decoder chip.
    function automatic region_e decode_addr(input logic [15:0] addr);
        region_e r;
        r = REG_NONE;
        if (addr <= RAM_HI) begin
            r = REG_RAM;
        end else if (addr >= ROM_LO) begin
            r = REG_ROM;
        end else if (addr >= RSVD_LO && addr <= RSVD_HI) begin
            r = REG_NONE;
        end else if (addr >= IO_BASE && addr < (IO_BASE + (IO_SLOT_SIZE << 2))) begin
            case (addr[5:4])
                2'd0:    r = REG_IO0;
                2'd1:    r = REG_IO1;
                2'd2:    r = REG_IO2;
                default: r = REG_IO3;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/wait_cfg_regs.sv
// Per-I/O-slot wait configuration: 4 x (wait count + external-ready enable).
// Latency: write takes effect on the cfg_we clock; reads are combinational.
// Backpressure: none, a write is always accepted.
//
// Ports: clk/rst (async active-high), cfg_we/cfg_slot/cfg_wait/cfg_ext write
// port, slot_wait/slot_ext expose every slot for the cycle-start latch mux.
module wait_cfg_regs
    import bus_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int IO_WAIT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_slot,
    input  logic [CNT_W-1:0]      cfg_wait,
    input  logic                  cfg_ext,
    output logic [3:0][CNT_W-1:0] slot_wait,
    output logic [3:0]            slot_ext
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_wait <= {4{CNT_W'(IO_WAIT)}};
            slot_ext  <= '0;
        end else if (cfg_we) begin
            slot_wait[cfg_slot] <= cfg_wait;
            slot_ext[cfg_slot]  <= cfg_ext;
        end
    end

endmodule

// File: rtl/bus_wait_ctrl.sv
// JB-8 wait-state controller: stretches CPU MRDY per decoded region, optional external ready.
// Latency: mrdy falls one clock after cycle_start; low W clocks, plus EXT clocks if enabled.
// Backpressure: cycle_start outside IDLE is ignored; EXT wait bounded by TIMEOUT.
//
// Ports: clk/rst (async active-high); cycle_start + active-low region selects
// from the decoder; io_rdy_N per-slot device ready; cfg_* slot config write;
// timeout_clr; outputs mrdy (0 = stretch), busy, sticky timeout.
module bus_wait_ctrl
    import bus_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int RAM_WAIT = 0,
    parameter int ROM_WAIT = 1,
    parameter int IO_WAIT  = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cycle_start,
    input  logic             ram_sel_N,
    input  logic             rom_sel_N,
    input  logic [3:0]       io_sel_N,
    input  logic [3:0]       io_rdy_N,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_slot,
    input  logic [CNT_W-1:0] cfg_wait,
    input  logic             cfg_ext,
    input  logic             timeout_clr,
    output logic             mrdy,
    output logic             busy,
    output logic             timeout
);

    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [3:0][CNT_W-1:0] slot_wait;
    logic [3:0]            slot_ext;

    wait_cfg_regs #(
        .CNT_W  (CNT_W),
        .IO_WAIT(IO_WAIT)
    ) u_cfg (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_slot (cfg_slot),
        .cfg_wait (cfg_wait),
        .cfg_ext  (cfg_ext),
        .slot_wait(slot_wait),
        .slot_ext (slot_ext)
    );

    region_e          region;
    logic [CNT_W-1:0] sel_wait;
    logic             sel_ext;
    logic [1:0]       sel_slot;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic             ext_q, ext_d;
    logic [1:0]       slot_q, slot_d;
    logic             timeout_q, timeout_d;
    logic             mrdy_q, busy_q;

    // Priority encoder: io0 > io1 > io2 > io3 > ROM > RAM > NONE.
    always_comb begin
        region = REG_NONE;
        if      (!io_sel_N[0]) region = REG_IO0;
        else if (!io_sel_N[1]) region = REG_IO1;
        else if (!io_sel_N[2]) region = REG_IO2;
        else if (!io_sel_N[3]) region = REG_IO3;
        else if (!rom_sel_N)   region = REG_ROM;
        else if (!ram_sel_N)   region = REG_RAM;
    end

    always_comb begin
        sel_wait = '0;
        sel_ext  = 1'b0;
        sel_slot = 2'd0;
        case (region)
            REG_RAM: sel_wait = CNT_W'(RAM_WAIT);
            REG_ROM: sel_wait = CNT_W'(ROM_WAIT);
            REG_IO0: sel_slot = 2'd0;
            REG_IO1: sel_slot = 2'd1;
            REG_IO2: sel_slot = 2'd2;
            REG_IO3: sel_slot = 2'd3;
            default: sel_slot = 2'd0;
        endcase
        if (region inside {REG_IO0, REG_IO1, REG_IO2, REG_IO3}) begin
            sel_wait = slot_wait[sel_slot];
            sel_ext  = slot_ext[sel_slot];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        ext_d     = ext_q;
        slot_d    = slot_q;
        timeout_d = timeout_q;

        // Clear first so a timeout expiring on the same clock overrides it.
        if (timeout_clr) timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cycle_start) begin
                    ext_d  = sel_ext;
                    slot_d = sel_slot;
                    if (sel_wait != '0) begin
                        state_d = WAIT;
                        cnt_d   = sel_wait;
                    end else if (sel_ext) begin
                        state_d = EXT;
                        tcnt_d  = '0;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d = '0;
                    if (ext_q) begin
                        state_d = EXT;
                        tcnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            EXT: begin
                if (!io_rdy_N[slot_q]) begin
                    state_d = IDLE;
                end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // mrdy/busy are registered from the next state so they move on the same
    // edge as the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            ext_q     <= 1'b0;
            slot_q    <= 2'd0;
            timeout_q <= 1'b0;
            mrdy_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            ext_q     <= ext_d;
            slot_q    <= slot_d;
            timeout_q <= timeout_d;
            mrdy_q    <= (state_d == IDLE);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign mrdy    = mrdy_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
